serial_sub_ctrl: RTL
====================

# serial_sub_ctrl

Bit-serial multi-bit subtractor controller. Captures two WIDTH-bit operands on a start handshake, then steps a single full-subtractor cell (difference = a^b^bin, borrow = ~a&b | ~(a^b)&bin) LSB-first over WIDTH cycles, holding the running borrow in a register. The final difference and borrow are presented with a one-cycle done pulse. It lets the full-subtractor datapath serve arbitrary operand widths with one cell of area.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- a  input  WIDTH  minuend, sampled on accepted start
- b  input  WIDTH  subtrahend, sampled on accepted start
- bin  input  1  initial borrow-in, sampled on accepted start (present only with SERIAL_SUB_BIN_EN)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- diff  output  WIDTH  registered a−b−bin (mod 2^WIDTH), held until next accepted start
- borrow_out  output  1  final borrow (1 = a < b+bin as unsigned), held with diff

## Operation
- One clock; reset is synchronous and active-high.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On start=1, load a_sh←a, b_sh←b, borrow_reg←initial borrow (bin or 0), cnt←0, and go to RUN.
- RUN: busy=1. Each edge does the following:
  - Apply the cell to a_sh[0], b_sh[0] and borrow_reg.
  - Shift the diff bit into diff_sh from the MSB side. Shift a_sh and b_sh right.
  - Set borrow_reg←cell borrow. Increment cnt.
  - On the edge where cnt reaches WIDTH−1, also copy diff_sh (with the final bit) to diff and the cell borrow to borrow_out, then go to DONE.
- DONE: done=1, busy=0, for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE and goes to RUN, giving back-to-back operation.
  - Otherwise go to IDLE.
- start while in RUN is ignored. Operands are not re-sampled, and no error is flagged.
- diff and borrow_out change only on the RUN→DONE edge and on reset. They are not cleared on a new start.
- cnt width is $clog2(WIDTH). No wrap occurs because RUN exits at WIDTH−1.

## Timing
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0. Internal shift registers, cnt and borrow_reg are all 0.
- Reset during RUN or DONE aborts the operation: the next cycle is IDLE with all outputs at reset values. Reset wins over a simultaneous start.
- Latency: start is sampled at edge E0, busy rises after E0, and edges E1..EWIDTH perform the bit steps.
  - done=1 and the new diff/borrow_out are visible in the cycle after EWIDTH. That is WIDTH+1 edges from accepting start to done.
- Throughput, back-to-back: one result every WIDTH+1 cycles.
- busy is low in the DONE cycle. It rises again after the edge that accepts a new start.

## Configuration
- SERIAL_SUB_BIN_EN defined: bin port exists. borrow_reg is initialised from bin at accept, and results equal a−b−bin.
- Undefined: no bin port. borrow_reg is initialised to 0, and results equal a−b.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start for one cycle: busy for 8 cycles, done pulses exactly 9 edges after accept, diff=0x1E, borrow_out=0.
- a=0x00, b=0x01: diff=0xFF, borrow_out=1. Also a=0x80, b=0x80: diff=0x00, borrow_out=0. Also a=0xFF, b=0x00: diff=0xFF, borrow_out=0.
- Start pulsed again mid-RUN with different operands:
  - It is ignored; the first result is unchanged and done fires once.
  - start held high continuously produces back-to-back results, each with done spaced 9 cycles apart.
- Assert rst on the 4th RUN cycle: the next cycle shows IDLE, busy=0, done=0, diff=0x00, borrow_out=0, and no done pulse follows. A later start completes correctly.
- In the DONE cycle of 0x5A−0x3C, start with a=0x03, b=0x05: the first result reads 0x1E/0. Nine edges later, done shows diff=0xFE, borrow_out=1.
- With SERIAL_SUB_BIN_EN and bin=1:
  - a=0x10, b=0x01 gives diff=0x0E, borrow_out=0.
  - a=0x00, b=0x00 gives diff=0xFF, borrow_out=1.
- Without the macro, the same 0x10−0x01 case gives diff=0x0F.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell stepped LSB-first over WIDTH cycles.
// Optional feature macro SERIAL_SUB_BIN_EN adds a borrow-in port sampled with the operands.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
    input  logic             bin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] diff_sh_r;
    logic             borrow_r;
    logic [CW-1:0]    cnt_r;

    logic             cell_diff_s;
    logic             cell_borrow_s;
    logic             init_borrow_s;

    // Returns {borrow, difference} of a single full-subtractor cell.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        logic d;
        logic bo;
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
        return {bo, d};
    endfunction

`ifdef SERIAL_SUB_BIN_EN
    assign init_borrow_s = bin;
`else
    assign init_borrow_s = 1'b0;
`endif

    // Combinational subtractor cell on the current LSBs and running borrow.
    always_comb begin
        cell_diff_s   = 1'b0;
        cell_borrow_s = 1'b0;
        {cell_borrow_s, cell_diff_s} = full_sub(a_sh_r[0], b_sh_r[0], borrow_r);
    end

    // Control FSM with datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            a_sh_r     <= '0;
            b_sh_r     <= '0;
            diff_sh_r  <= '0;
            borrow_r   <= 1'b0;
            cnt_r      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        borrow_r <= init_borrow_s;
                        cnt_r    <= '0;
                        busy     <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    diff_sh_r <= {cell_diff_s, diff_sh_r[WIDTH-1:1]};
                    a_sh_r    <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r    <= {1'b0, b_sh_r[WIDTH-1:1]};
                    borrow_r  <= cell_borrow_s;
                    cnt_r     <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        diff       <= {cell_diff_s, diff_sh_r[WIDTH-1:1]};
                        borrow_out <= cell_borrow_s;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state_r    <= DONE;
                    end else begin
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
